v850_fetch_align: RTL and testbench

Instruction fetch-align buffer for the V850 core. Accepts a stream of fetch beats of one or more 16-bit halfwords, stores them in a circular halfword queue, determines each instruction's length (16/32/48 bits) from its first halfword, and presents one complete, left-aligned instruction with its PC to the decoder per handshake. Sits between the fetch unit and the decode stage and feeds the decoder's instruction register.

---
 rtl/v850_pkg.sv | 30 +++
 rtl/v850_ilen_decode.sv | 11 +
 rtl/v850_fetch_align.sv | 108 ++++++++++
 tb/tb_v850_fetch_align.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/v850_pkg.sv
// V850 fetch-align shared types: instruction length encoding and
// the opcode patterns that select 32/48-bit formats.
package v850_pkg;

  typedef logic [1:0] ilen_t;

  localparam ilen_t ILEN16 = 2'd1;
  localparam ilen_t ILEN32 = 2'd2;
  localparam ilen_t ILEN48 = 2'd3;

  localparam logic [10:0] JARL32_OP  = 11'b00000010111;
  localparam logic [10:0] JMP32_OP   = 11'b00000110111;
  localparam logic [10:0] MOV32_OP   = 11'b00000110001;
  localparam logic [9:0]  DISPOSE_OP = 10'b0000011001;

  function automatic ilen_t v850_ilen(input logic [15:0] h);
    ilen_t r;
    if (h[15:5] == JARL32_OP ||
        h[15:5] == JMP32_OP ||
        h[15:5] == MOV32_OP)
      r = ILEN48;
    else if (h[10:5] >= 6'b110000 ||
             h[15:6] == DISPOSE_OP)
      r = ILEN32;
    else
      r = ILEN16;
    return r;
  endfunction

endpackage

// File: rtl/v850_ilen_decode.sv
// Combinational instruction-length decode of a first halfword.
module v850_ilen_decode
  import v850_pkg::*;
(
  input  logic [15:0] hw_i,
  output ilen_t       len_o
);

  assign len_o = v850_ilen(hw_i);

endmodule

// File: rtl/v850_fetch_align.sv
// Fetch-align halfword queue: accepts fetch beats and presents one
// complete left-aligned instruction with its PC per handshake.
module v850_fetch_align
  import v850_pkg::*;
#(
  parameter int IN_HW = 2,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*IN_HW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [47:0]           out_instr,
  output logic [1:0]            out_len,
  output logic [31:0]           out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          skip_q, skip_d;

  logic [15:0]   hd0, hd1, hd2;
  ilen_t         len;
  logic          push, pop;
  logic [CW-1:0] n_push, n_pop;

  // Empty queue shows a zero head so stale storage never leaks out
  assign hd0 = (cnt_q == '0) ? 16'h0 : mem_q[rd_q];
  assign hd1 = mem_q[rd_q + PW'(1)];
  assign hd2 = mem_q[rd_q + PW'(2)];

  v850_ilen_decode u_dec (
    .hw_i  (hd0),
    .len_o (len)
  );

  assign out_valid = (cnt_q != '0) && (cnt_q >= CW'(len));
  assign out_len   = len;
  assign out_pc    = pc_q;
  assign out_instr = {(len == ILEN48) ? hd2 : 16'h0,
                      (len != ILEN16) ? hd1 : 16'h0,
                      hd0};

  assign in_ready = (CW'(DEPTH) - cnt_q) >= CW'(IN_HW);

  assign push   = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready && !flush;
  assign n_push = push ? CW'(IN_HW) - CW'(skip_q) : '0;
  assign n_pop  = pop ? CW'(len) : '0;

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    skip_d = skip_q;
    if (flush) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      pc_d   = flush_pc & ~32'h1;
      skip_d = (IN_HW == 2) && flush_pc[1];
    end else begin
      rd_d  = rd_q + PW'(n_pop);
      wr_d  = wr_q + PW'(n_push);
      cnt_d = cnt_q + n_push - n_pop;
      if (pop) pc_d = pc_q + (32'(len) << 1);
      if (push) skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      pc_q   <= '0;
      skip_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

  // A skipped beat drops halfword 0 and packs the rest at wr_q
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      for (int i = 0; i < IN_HW; i++) begin
        if (!(skip_q && i == 0))
          mem_q[wr_q + PW'(i) - PW'(skip_q)] <= in_data[16*i +: 16];
      end
    end
  end

endmodule

// File: tb/tb_v850_fetch_align.sv
// Self-checking bench for v850_fetch_align: queue-level reference
// model compared every cycle plus directed literal expectations.
module tb_v850_fetch_align;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic        out_valid, out_ready;
  logic [31:0] flush_pc, in_data, out_pc;
  logic [47:0] out_instr;
  logic [1:0]  out_len;

  always #5 clk = ~clk;

  v850_fetch_align #(.IN_HW(2), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_len   (out_len),
    .out_pc    (out_pc)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  logic [15:0] mq [$];
  logic [31:0] mpc = 0;
  bit          mskip = 0;

  function automatic int mlen(logic [15:0] h);
    if (h[15:5] == 11'h017 || h[15:5] == 11'h037 || h[15:5] == 11'h031)
      return 3;
    if (h[10:5] >= 6'd48 || h[15:6] == 10'h019)
      return 2;
    return 1;
  endfunction

  function automatic bit mvalid();
    return mq.size() >= 1 && mq.size() >= mlen(mq[0]);
  endfunction

  function automatic bit mready();
    return (8 - mq.size()) >= 2;
  endfunction

  function automatic logic [47:0] minstr();
    logic [47:0] r;
    int n;
    r = '0;
    n = mlen(mq[0]);
    for (int i = 0; i < n; i++) r[16*i +: 16] = mq[i];
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain halfword queue updated at each edge
  always @(posedge clk) begin : model
    bit v, r;
    int n;
    v = mvalid();
    r = mready();
    n = v ? mlen(mq[0]) : 0;
    if (!rst_n) begin
      mq.delete();
      mpc = 0;
      mskip = 0;
    end else if (flush) begin
      mq.delete();
      mpc = flush_pc & ~32'h1;
      mskip = flush_pc[1];
    end else begin
      if (v && out_ready) begin
        repeat (n) void'(mq.pop_front());
        mpc = mpc + 32'(2 * n);
      end
      if (in_valid && r) begin
        if (!mskip) mq.push_back(in_data[15:0]);
        mq.push_back(in_data[31:16]);
        mskip = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_valid", out_valid, mvalid());
      chk("m_in_ready", in_ready, mready());
      chk("m_pc", out_pc, mpc);
      if (mvalid()) begin
        chk("m_instr", out_instr, minstr());
        chk("m_len", out_len, mlen(mq[0]));
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] d, input bit r,
                     input bit f = 0, input logic [31:0] fp = 0);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    flush_pc  = fp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] h0;
    rst_n = 0;
    cyc(0, 0, 0);
    chk_on = 1;
    cyc(0, 0, 0);
    rst_n = 1;
    cyc(0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_len", out_len, 1);

    cyc(1, 32'h0060_0060, 0);
    chk("nop_valid", out_valid, 1);
    chk("nop_instr", out_instr, 48'h0060);
    chk("nop_len", out_len, 1);
    chk("nop_pc0", out_pc, 0);
    cyc(0, 0, 1);
    chk("nop_pc1", out_pc, 2);
    cyc(0, 0, 1);
    chk("nop_pc2", out_pc, 4);
    chk("nop_empty", out_valid, 0);

    cyc(0, 0, 0, 1, 32'h100);
    cyc(1, 32'h1234_02E5, 0);
    chk("j48_partial", out_valid, 0);
    cyc(1, 32'h0000_5678, 0);
    chk("j48_valid", out_valid, 1);
    chk("j48_instr", out_instr, 48'h5678_1234_02E5);
    chk("j48_len", out_len, 3);
    chk("j48_pc", out_pc, 32'h100);
    cyc(0, 0, 1);
    chk("j48_next_pc", out_pc, 32'h106);
    cyc(0, 0, 1);
    chk("j48_tail_pc", out_pc, 32'h108);

    cyc(0, 0, 0, 1, 32'h203);
    cyc(1, 32'h0060_DEAD, 0);
    chk("mis_instr", out_instr, 48'h0060);
    chk("mis_pc", out_pc, 32'h202);
    cyc(0, 0, 1);
    chk("mis_empty", out_valid, 0);
    chk("mis_pc2", out_pc, 32'h204);

    cyc(0, 0, 0, 1, 32'h0);
    for (int k = 0; k < 4; k++)
      cyc(1, {16'(2*k+2), 16'(2*k+1)}, 0);
    chk("full_ready", in_ready, 0);
    chk("full_head", out_instr, 48'h1);
    for (int i = 0; i < 20; i++) begin
      h0 = (i % 3 == 2) ? (16'h0600 | 16'(i)) : 16'(16'h0100 + 2*i);
      cyc(1, {16'(16'h0200 + i), h0}, 1);
      if (i == 0) chk("wrap_head", out_instr, 48'h2);
    end

    cyc(0, 0, 0, 1, 32'h400);
    cyc(1, 32'h1111_0600, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(i % 2 == 0, 32'h0060_0060, 0);
      chk("stall_instr", out_instr, 48'h1111_0600);
      chk("stall_len", out_len, 2);
      chk("stall_pc", out_pc, 32'h400);
    end

    cyc(1, 32'h0070_0071, 1, 1, 32'h1235);
    chk("fp_valid", out_valid, 0);
    chk("fp_pc", out_pc, 32'h1234);
    chk("fp_ready", in_ready, 1);
    cyc(1, 32'h0061_0062, 0);
    chk("fp_instr", out_instr, 48'h0062);
    chk("fp_pc2", out_pc, 32'h1234);

    cyc(1, 32'h0060_0060, 0);
    rst_n = 0;
    cyc(1, 32'h0060_0060, 1, 1, 32'h88);
    chk("rs_valid", out_valid, 0);
    chk("rs_pc", out_pc, 0);
    chk("rs_ready", in_ready, 1);
    chk("rs_instr", out_instr, 0);
    chk("rs_len", out_len, 1);
    rst_n = 1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
